// File: rtl/ascon_permutation_iter.sv
// Iterative Ascon-p[rnd] permutation core, UNROLL rounds per clock.
// Shared state type lives in ascon_pkg; word i of the state is S_i.
package ascon_pkg;
    typedef logic [4:0][63:0] ascon_state_t;
endpackage

module ascon_permutation_iter
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [4:0]   rnd_i,
    input  ascon_state_t state_i,
    output logic         ready_o,
    output logic         done_o,
    output logic         err_o,
    output ascon_state_t state_o
);

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
        $error("UNROLL must be 1, 2 or 4");
    end

    typedef enum logic {IDLE, RUN} fsm_t;

    localparam logic [15:0][7:0] RC = {
        8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96, 8'ha5, 8'hb4,
        8'hc3, 8'hd2, 8'he1, 8'hf0, 8'h0f, 8'h1e, 8'h2d, 8'h3c
    };

    function automatic logic [63:0] ror(logic [63:0] x, int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic ascon_state_t ascon_round(ascon_state_t s,
                                                 logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        ascon_state_t r;
        x0 = s[0];
        x1 = s[1];
        x2 = s[2] ^ {56'd0, RC[i]};
        x3 = s[3];
        x4 = s[4];
        // bit-sliced 5-bit S-box applied to all 64 columns at once
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        r[0] = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        r[1] = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        r[2] = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        r[3] = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        r[4] = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return r;
    endfunction

    fsm_t         fsm_q, fsm_d;
    ascon_state_t state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic         legal;
    logic [4:0]   base;
    logic [4:0]   idx_nxt;
    ascon_state_t perm_in;
    ascon_state_t chain [UNROLL+1];

    assign legal = (rnd_i != 5'd0) && (rnd_i <= 5'd16) &&
                   ((rnd_i & 5'(UNROLL - 1)) == 5'd0);

    // IDLE starts from the input; RUN continues from the register
    assign base    = (fsm_q == IDLE) ? 5'd16 - rnd_i : idx_q;
    assign perm_in = (fsm_q == IDLE) ? state_i : state_q;
    assign idx_nxt = base + 5'(UNROLL);

    assign chain[0] = perm_in;
    for (genvar g = 0; g < UNROLL; g++) begin : g_rounds
        assign chain[g+1] = ascon_round(chain[g], base[3:0] + 4'(g));
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                if (start_i && legal) begin
                    state_d = chain[UNROLL];
                    idx_d   = idx_nxt;
                    if (idx_nxt == 5'd16) done_d = 1'b1;
                    else                  fsm_d  = RUN;
                end else if (start_i) begin
                    err_d = 1'b1;
                end
            end
            RUN: begin
                state_d = chain[UNROLL];
                idx_d   = idx_nxt;
                if (idx_nxt == 5'd16) begin
                    fsm_d  = IDLE;
                    done_d = 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            idx_q   <= 5'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign ready_o = (fsm_q == IDLE);
    assign done_o  = done_q;
    assign err_o   = err_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_ascon_permutation_iter.sv
// Directed bench for ascon_permutation_iter: UNROLL=1 and UNROLL=4
// instances checked against a table-driven Ascon-p model.
module tb_ascon_permutation_iter;
    import ascon_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start [2];
    logic [4:0]   rnd   [2];
    ascon_state_t sin   [2];
    logic         rdy   [2];
    logic         dn    [2];
    logic         er    [2];
    ascon_state_t sout  [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ascon_permutation_iter #(.UNROLL(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .rnd_i(rnd[0]),
        .state_i(sin[0]), .ready_o(rdy[0]), .done_o(dn[0]),
        .err_o(er[0]), .state_o(sout[0])
    );

    ascon_permutation_iter #(.UNROLL(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .rnd_i(rnd[1]),
        .state_i(sin[1]), .ready_o(rdy[1]), .done_o(dn[1]),
        .err_o(er[1]), .state_o(sout[1])
    );

    logic [4:0] sbox_t [32] = '{
        5'd4,  5'd11, 5'd31, 5'd20, 5'd26, 5'd21, 5'd9,  5'd2,
        5'd27, 5'd5,  5'd8,  5'd18, 5'd29, 5'd3,  5'd6,  5'd28,
        5'd30, 5'd19, 5'd7,  5'd14, 5'd0,  5'd13, 5'd17, 5'd24,
        5'd16, 5'd12, 5'd1,  5'd25, 5'd22, 5'd10, 5'd15, 5'd23
    };

    task automatic check(string tag, logic [319:0] got, logic [319:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] rotr(logic [63:0] x, int n);
        logic [63:0] y;
        for (int j = 0; j < 64; j++) y[j] = x[(j + n) % 64];
        return y;
    endfunction

    function automatic ascon_state_t ref_round(ascon_state_t s, int i);
        ascon_state_t t;
        logic [4:0] col, o;
        s[2][7:0] = s[2][7:0] ^ {4'(3 - i), 4'(12 + i)};
        for (int j = 0; j < 64; j++) begin
            col = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
            o = sbox_t[col];
            for (int w = 0; w < 5; w++) t[w][j] = o[4-w];
        end
        s[0] = t[0] ^ rotr(t[0], 19) ^ rotr(t[0], 28);
        s[1] = t[1] ^ rotr(t[1], 61) ^ rotr(t[1], 39);
        s[2] = t[2] ^ rotr(t[2], 1)  ^ rotr(t[2], 6);
        s[3] = t[3] ^ rotr(t[3], 10) ^ rotr(t[3], 17);
        s[4] = t[4] ^ rotr(t[4], 7)  ^ rotr(t[4], 41);
        return s;
    endfunction

    function automatic ascon_state_t ref_perm(ascon_state_t s, int r);
        for (int i = 16 - r; i < 16; i++) s = ref_round(s, i);
        return s;
    endfunction

    function automatic ascon_state_t rand_state();
        ascon_state_t s;
        for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
        return s;
    endfunction

    task automatic launch(int d, ascon_state_t s, logic [4:0] r);
        start[d] = 1'b1;
        sin[d]   = s;
        rnd[d]   = r;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    // exp_edges counts clock edges after launch() has returned
    task automatic wait_done(int d, int exp_edges, ascon_state_t exp,
                             string tag);
        int n = -1;
        for (int c = 0; c <= 24; c++) begin
            if (dn[d]) begin
                n = c;
                break;
            end
            @(posedge clk); #1;
        end
        check({tag, " latency"}, 320'(n), 320'(exp_edges));
        check({tag, " state"}, sout[d], exp);
        check({tag, " ready"}, 320'(rdy[d]), 320'(1));
        check({tag, " err"}, 320'(er[d]), 320'(0));
    endtask

    task automatic run_err(int d, logic [4:0] r, string tag);
        ascon_state_t prev = sout[d];
        launch(d, rand_state(), r);
        check({tag, " err pulse"}, 320'(er[d]), 320'(1));
        check({tag, " no done"}, 320'(dn[d]), 320'(0));
        check({tag, " ready"}, 320'(rdy[d]), 320'(1));
        @(posedge clk); #1;
        check({tag, " err drop"}, 320'(er[d]), 320'(0));
        check({tag, " no done2"}, 320'(dn[d]), 320'(0));
        check({tag, " state kept"}, sout[d], prev);
    endtask

    ascon_state_t a, b, exp_a, exp_b;
    int dones;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b1;
            rnd[d]   = 5'd12;
            sin[d]   = rand_state();
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst ready", 320'(rdy[d]), 320'(1));
            check("rst done", 320'(dn[d]), 320'(0));
            check("rst err", 320'(er[d]), 320'(0));
            check("rst state", sout[d], '0);
        end
        start[0] = 1'b0;
        start[1] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 500; k++) begin
            a = rand_state();
            exp_a = ref_perm(a, 12);
            exp_b = ref_perm(a, 8);
            launch(0, a, 5'd12);
            wait_done(0, 11, exp_a, "u1 p12");
            launch(1, a, 5'd12);
            wait_done(1, 2, sout[0], "u4 p12");
            launch(0, a, 5'd8);
            wait_done(0, 7, exp_b, "u1 p8");
            launch(1, a, 5'd8);
            wait_done(1, 1, sout[0], "u4 p8");
        end

        a = rand_state();
        launch(1, a, 5'd4);
        wait_done(1, 0, ref_perm(a, 4), "u4 p4");

        run_err(1, 5'd6, "u4 rnd6");
        run_err(0, 5'd0, "u1 rnd0");
        run_err(0, 5'd17, "u1 rnd17");
        run_err(1, 5'd0, "u4 rnd0");

        a = rand_state();
        b = rand_state();
        launch(0, a, 5'd12);
        repeat (3) begin @(posedge clk); #1; end
        launch(0, b, 5'd8);
        wait_done(0, 7, ref_perm(a, 12), "busy ignore");

        launch(0, a, 5'd8);
        wait_done(0, 7, ref_perm(a, 8), "b2b first");
        launch(0, b, 5'd12);
        wait_done(0, 11, ref_perm(b, 12), "b2b second");

        launch(0, a, 5'd12);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst state", sout[0], '0);
        check("midrst ready", 320'(rdy[0]), 320'(1));
        dones = 0;
        repeat (14) begin
            if (dn[0]) dones++;
            @(posedge clk); #1;
        end
        check("midrst no done", 320'(dones), 320'(0));
        launch(0, b, 5'd12);
        wait_done(0, 11, ref_perm(b, 12), "after rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
